latch_write_arbiter: RTL and testbench
======================================

// Module: latch_write_arbiter
// PURPOSE
//  Round-robin arbiter and enable sequencer for one shared latch-based master-slave register.
//  NREQ requesters compete for write access to the register.
//  The block selects one requester and drives its data to the latch pair.
//  It generates non-overlapping master/slave enables with programmable width and dead time, then acks the requester.
//  It sits between the requesting logic and the latch-pair storage; the latches themselves are external.
// PARAMETERS
//  NREQ   4  number of requesters (>=2)
//  WIDTH  8  data width per requester and of lat_d
//  PULSE  2  cycles each enable (en_m, en_s) is held high (>=1)
//  GAP    1  dead-time cycles with both enables low between en_m fall and en_s rise (>=1)
// PORTS
//  clk     in   1           rising-edge clock
//  rst_n   in   1           asynchronous active-low reset
//  req     in   NREQ        per-requester write request, level
//  wdata   in   NREQ*WIDTH  requester k data on wdata[k*WIDTH +: WIDTH]
//  grant   out  NREQ        one-hot, held for whole transaction
//  ack     out  NREQ        one-cycle completion pulse to granted requester
//  owner   out  clog2(NREQ) index of granted requester (valid while busy)
//  lat_d   out  WIDTH       data to master latch D input
//  en_m    out  1           master latch enable
//  en_s    out  1           slave latch enable
//  busy    out  1           transaction in progress (SETUP..ACK)
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE; grant=0, ack=0, owner=0, lat_d=0, en_m=0, en_s=0, busy=0; rr pointer=0.
//  All outputs are registered. Release of rst_n is synchronous to clk.
//  FSM: IDLE -> SETUP -> MOPEN -> GAP -> SOPEN -> ACK -> IDLE.
//  IDLE: sample req each cycle; none -> stay.
//   Otherwise select first set bit scanning from ptr upward, mod NREQ.
//   Next cycle: SETUP, grant[k]=1, owner=k, busy=1, lat_d<=wdata lane k (captured once).
//  SETUP: 1 cycle, data setup; en_m=en_s=0.
//  MOPEN: en_m=1 for PULSE cycles (down-counter), en_s=0.
//  GAP: both enables 0 for GAP cycles.
//  SOPEN: en_s=1 for PULSE cycles, en_m=0.
//  ACK: 1 cycle, ack[k]=1, grant still high, enables 0.
//   Next cycle: IDLE, grant=0, busy=0, ptr<=(k+1) mod NREQ.
//  Latency: req sampled in IDLE at T0 -> ack at T0+2+2*PULSE+GAP (defaults: T0+7).
//  Throughput: back-to-back grants every 3+2*PULSE+GAP cycles (defaults: 8).
//  Invariants: en_m & en_s never both 1.
//   Between en_m fall and en_s rise there are >= GAP cycles.
//   Between en_s fall and the next en_m rise there are >= 3 cycles (ACK, IDLE, SETUP).
//  lat_d is stable from SETUP through ACK; it holds its last value while IDLE.
//  req drop or wdata change after grant: ignored; transaction completes and ack is still issued.
//  Requester must drop req the cycle after ack; req still high in IDLE is a new request.
//  Only the granted requester ever sees ack; ack and grant are one-hot or zero.
//  Reset mid-transaction: enables drop asynchronously; latch content then undefined; no ack issued.
//  Counters are sized clog2(max(PULSE,GAP)+1); no wrap beyond terminal count.
// TESTING
//  1. req=4'b0100, lane2=8'hA5 at T0 -> grant=0100/owner=2/lat_d=A5 T1; en_m T2-T3; en_s T5-T6; ack[2] T7; busy=0 T8.
//  2. req=4'b1111 held (drop on ack, re-raise) -> grant order 0,1,2,3,0; acks 8 cycles apart.
//  3. Random req/wdata 10k cycles -> assert never en_m&en_s; en_m->en_s gap >= GAP; scoreboard: slave-latch model Q == acked data.
//  4. rst_n low during MOPEN -> en_m/grant/busy = 0 same cycle; after release req=4'b1001 -> grant[0] first (ptr reset).
//  5. req[1] dropped and lane1 changed 55->FF in MOPEN -> lat_d stays 55, ack[1] still at T7.
//  6. PULSE=1, GAP=3, single req at T0 -> en_m T2, en_s T6, ack T7.

Source files
------------

// File: rtl/latch_write_arbiter.sv
// Round-robin write arbiter driving one external master/slave latch pair.
// Sequences non-overlapping master/slave enables and acks the granted requester.
module latch_write_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int PULSE = 2,
    parameter int GAP   = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   wdata,
    output logic [NREQ-1:0]         grant,
    output logic [NREQ-1:0]         ack,
    output logic [$clog2(NREQ)-1:0] owner,
    output logic [WIDTH-1:0]        lat_d,
    output logic                    en_m,
    output logic                    en_s,
    output logic                    busy
);

    localparam int          OW   = $clog2(NREQ);
    localparam int          MAXC = (PULSE > GAP) ? PULSE : GAP;
    localparam int          CW   = $clog2(MAXC + 1);
    localparam int unsigned NU   = NREQ;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_MOPEN,
        S_GAP,
        S_SOPEN,
        S_ACK
    } state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [OW-1:0]   ptr, ptr_n;
    logic [OW-1:0]   sel, idx;
    logic            found;
    logic [WIDTH-1:0] lanes [NREQ];

    always_comb begin
        for (int unsigned i = 0; i < NU; i++) begin
            lanes[i] = wdata[i*WIDTH +: WIDTH];
        end
    end

    // First requester at or above ptr, wrapping modulo NREQ.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = '0;
        for (int unsigned i = 0; i < NU; i++) begin
            idx = OW'((32'(ptr) + i) % NU);
            if (!found && req[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        ptr_n   = ptr;
        case (state)
            S_IDLE:  if (found) state_n = S_SETUP;
            S_SETUP: begin
                state_n = S_MOPEN;
                cnt_n   = CW'(PULSE - 1);
            end
            S_MOPEN: begin
                if (cnt == '0) begin
                    state_n = S_GAP;
                    cnt_n   = CW'(GAP - 1);
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            S_GAP: begin
                if (cnt == '0) begin
                    state_n = S_SOPEN;
                    cnt_n   = CW'(PULSE - 1);
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            S_SOPEN: begin
                if (cnt == '0) state_n = S_ACK;
                else           cnt_n   = cnt - 1'b1;
            end
            S_ACK: begin
                state_n = S_IDLE;
                ptr_n   = (owner == OW'(NREQ - 1)) ? '0 : owner + 1'b1;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so every port comes straight off a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            ptr   <= '0;
            grant <= '0;
            ack   <= '0;
            owner <= '0;
            lat_d <= '0;
            en_m  <= 1'b0;
            en_s  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            ptr   <= ptr_n;
            busy  <= (state_n != S_IDLE);
            en_m  <= (state_n == S_MOPEN);
            en_s  <= (state_n == S_SOPEN);
            ack   <= (state_n == S_ACK) ? grant : '0;
            if (state == S_IDLE && found) begin
                grant      <= '0;
                grant[sel] <= 1'b1;
                owner      <= sel;
                lat_d      <= lanes[sel];
            end else if (state == S_ACK) begin
                grant <= '0;
            end
        end
    end

endmodule

// File: tb/tb_latch_write_arbiter.sv
// Randomised and directed bench for latch_write_arbiter against a
// transaction-timeline reference model and a latch-pair scoreboard.
module tb_latch_write_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int P  = 2;
    localparam int G  = 1;
    localparam int L  = 2 + 2*P + G;   // ack offset from the sampling edge

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] wdata = '0;
    logic [N-1:0]   grant, ack;
    logic [1:0]     owner;
    logic [W-1:0]   lat_d;
    logic           en_m, en_s, busy;

    logic [N-1:0]   req2 = '0;
    logic [N*W-1:0] wdata2 = '0;
    logic [N-1:0]   grant2, ack2;
    logic [1:0]     owner2;
    logic [W-1:0]   lat_d2;
    logic           en_m2, en_s2, busy2;

    int checks = 0;
    int errors = 0;

    // Reference model: offset into the current transaction (0 = idle).
    int         m_d = 0;
    int         m_ptr = 0;
    int         m_k = 0;
    logic [W-1:0] m_data = '0;
    logic [W-1:0] m_latd = '0;

    // Latch-pair model driven by the DUT enables.
    logic [W-1:0] lat_m = '0, lat_q = '0;
    int  since_m_fall = 0;
    logic prev_en_s = 1'b0;

    always #5 clk = ~clk;

    latch_write_arbiter #(.NREQ(N), .WIDTH(W), .PULSE(P), .GAP(G)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .wdata(wdata), .grant(grant),
        .ack(ack), .owner(owner), .lat_d(lat_d), .en_m(en_m), .en_s(en_s), .busy(busy)
    );

    latch_write_arbiter #(.NREQ(N), .WIDTH(W), .PULSE(1), .GAP(3)) dut2 (
        .clk(clk), .rst_n(rst_n), .req(req2), .wdata(wdata2), .grant(grant2),
        .ack(ack2), .owner(owner2), .lat_d(lat_d2), .en_m(en_m2), .en_s(en_s2), .busy(busy2)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_d = 0; m_ptr = 0; m_k = 0; m_latd = '0;
        since_m_fall = 0; prev_en_s = 1'b0;
    endtask

    task automatic model_edge();
        if (m_d == 0) begin
            if (req != '0) begin
                for (int i = 0; i < N; i++) begin
                    if (m_d == 0 && req[(m_ptr + i) % N]) begin
                        m_k = (m_ptr + i) % N;
                        m_d = 1;
                    end
                end
                m_data = wdata[m_k*W +: W];
                m_latd = m_data;
            end
        end else if (m_d == L) begin
            m_d   = 0;
            m_ptr = (m_k + 1) % N;
        end else begin
            m_d++;
        end
    endtask

    task automatic compare_all();
        logic [N-1:0] oh;
        logic x_busy, x_m, x_s;
        oh     = '0;
        oh[m_k] = 1'b1;
        x_busy = (m_d != 0);
        x_m    = (m_d >= 2) && (m_d <= 1 + P);
        x_s    = (m_d >= 2 + P + G) && (m_d <= 1 + 2*P + G);
        check("busy",  64'(busy),  64'(x_busy));
        check("grant", 64'(grant), x_busy ? 64'(oh) : 64'd0);
        check("ack",   64'(ack),   (m_d == L) ? 64'(oh) : 64'd0);
        check("en_m",  64'(en_m),  64'(x_m));
        check("en_s",  64'(en_s),  64'(x_s));
        check("lat_d", 64'(lat_d), 64'(m_latd));
        check("no_overlap", 64'(en_m & en_s), 64'd0);
        if (x_busy) check("owner", 64'(owner), 64'(m_k));
        // Latch pair: master transparent on en_m, slave copies master on en_s.
        if (en_m) lat_m = lat_d;
        if (en_s) lat_q = lat_m;
        if (en_m) since_m_fall = 0;
        else      since_m_fall++;
        if (en_s && !prev_en_s) check("gap_ms", 64'(since_m_fall >= G), 64'd1);
        prev_en_s = en_s;
        if (ack != '0) check("slave_q", 64'(lat_q), 64'(m_data));
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_busy",  64'(busy),  64'd0);
        check("rst_grant", 64'(grant), 64'd0);
        check("rst_en_m",  64'(en_m),  64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        // Reset state.
        #2;
        check("reset_busy",  64'(busy),  64'd0);
        check("reset_grant", 64'(grant), 64'd0);
        check("reset_lat_d", 64'(lat_d), 64'd0);
        check("reset_ack",   64'(ack),   64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single request, full timeline.
        req = 4'b0100;
        wdata = '0;
        wdata[2*W +: W] = 8'hA5;
        for (int t = 1; t <= 8; t++) begin
            step();
            if (t == 1) begin
                req = '0;
                check("t1_grant", 64'(grant), 64'h4);
                check("t1_owner", 64'(owner), 64'd2);
                check("t1_lat_d", 64'(lat_d), 64'hA5);
            end
            check("t_en_m", 64'(en_m), 64'(t == 2 || t == 3));
            check("t_en_s", 64'(en_s), 64'(t == 5 || t == 6));
            check("t_ack",  64'(ack),  (t == 7) ? 64'h4 : 64'h0);
            check("t_busy", 64'(busy), 64'(t <= 7));
        end

        // Reset during MOPEN, then pointer restarts at 0.
        req = 4'b1000;
        step();
        req = '0;
        step();
        step();
        check("pre_rst_en_m", 64'(en_m), 64'd1);
        do_reset();
        req = 4'b1001;
        step();
        check("post_rst_grant", 64'(grant), 64'h1);
        req = '0;
        repeat (8) step();

        // All requesting: round-robin order 0,1,2,3,0 with fixed spacing.
        do_reset();
        begin
            int order [$];
            int last_ack = -1;
            int cyc = 0;
            req = 4'hF;
            while (order.size() < 5 && cyc < 100) begin
                step();
                cyc++;
                if (ack != '0) begin
                    order.push_back(int'(owner));
                    if (last_ack >= 0) check("rr_spacing", 64'(cyc - last_ack), 64'(L + 1));
                    last_ack = cyc;
                    req = ~ack;
                end else begin
                    req = 4'hF;
                end
            end
            check("rr_count", 64'(order.size()), 64'd5);
            for (int i = 0; i < order.size(); i++) check("rr_order", 64'(order[i]), 64'(i % N));
        end
        req = '0;
        repeat (9) step();

        // Requester drops req and changes data mid-transaction.
        req = 4'b0010;
        wdata[1*W +: W] = 8'h55;
        for (int t = 1; t <= 8; t++) begin
            step();
            if (t == 2) begin
                req = '0;
                wdata[1*W +: W] = 8'hFF;
            end
            if (t >= 1 && t <= 7) check("hold_lat_d", 64'(lat_d), 64'h55);
            check("hold_ack", 64'(ack), (t == 7) ? 64'h2 : 64'h0);
        end

        // Second instance with PULSE=1, GAP=3.
        req2 = 4'b0001;
        wdata2[W-1:0] = 8'h3C;
        for (int t = 1; t <= 8; t++) begin
            step();
            if (t == 1) req2 = '0;
            check("p1_en_m", 64'(en_m2), 64'(t == 2));
            check("p1_en_s", 64'(en_s2), 64'(t == 6));
            check("p1_ack",  64'(ack2),  (t == 7) ? 64'h1 : 64'h0);
            check("p1_overlap", 64'(en_m2 & en_s2), 64'd0);
        end

        // Random traffic.
        for (int c = 0; c < 10000; c++) begin
            req   = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom_range(0, 15));
            wdata = {$urandom(), $urandom()} >> (64 - N*W);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
